// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if
//   Bundles every signal of the SDRAM arbiter except clock and reset.
//   master : the arbiter's view (requests, controller responses and read
//            data in; acks, valids, read data, controller command and busy out).
//   slave  : the opposite side (ROM download writer, game-side readers and the
//            SDRAM controller, or a testbench standing in for them).
//   Ports (master view):
//     wr_req/wr_addr/wr_data  in   download write request, held until wr_ack
//     wr_ack                  out  one-cycle write-accepted pulse
//     port_req/port_addr      in   per-port read requests, packed addresses
//     port_ack/port_valid     out  per-port accept / data-valid pulses
//     port_q                  out  registered read data shared by all ports
//     sdram_addr/data/we/req  out  command to the controller
//     sdram_ack/valid/q       in   controller handshake and read data
//     busy                    out  a transaction is outstanding
interface sdram_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 32
) ();
  logic                            wr_req;
  logic [ADDR_WIDTH-1:0]           wr_addr;
  logic [DATA_WIDTH-1:0]           wr_data;
  logic                            wr_ack;
  logic [NUM_PORTS-1:0]            port_req;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr;
  logic [NUM_PORTS-1:0]            port_ack;
  logic [NUM_PORTS-1:0]            port_valid;
  logic [DATA_WIDTH-1:0]           port_q;
  logic [ADDR_WIDTH-1:0]           sdram_addr;
  logic [DATA_WIDTH-1:0]           sdram_data;
  logic                            sdram_we;
  logic                            sdram_req;
  logic                            sdram_ack;
  logic                            sdram_valid;
  logic [DATA_WIDTH-1:0]           sdram_q;
  logic                            busy;

  modport master (
    input  wr_req, wr_addr, wr_data, port_req, port_addr,
           sdram_ack, sdram_valid, sdram_q,
    output wr_ack, port_ack, port_valid, port_q,
           sdram_addr, sdram_data, sdram_we, sdram_req, busy
  );

  modport slave (
    output wr_req, wr_addr, wr_data, port_req, port_addr,
           sdram_ack, sdram_valid, sdram_q,
    input  wr_ack, port_ack, port_valid, port_q,
           sdram_addr, sdram_data, sdram_we, sdram_req, busy
  );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Shares one SDRAM controller request/ack/valid interface between the ROM
//   download writer and NUM_PORTS game-side ROM readers. Exactly one
//   transaction is outstanding at a time. The write port always wins; read
//   ports are served lowest-index-first, or round-robin when the macro
//   SDRAM_ARB_ROUND_ROBIN_EN is defined.
//   Ports:
//     clk      in  system clock
//     reset_n  in  asynchronous active-low reset
//     bus      sdram_arbiter_if.master, all request/ack/data signals
module sdram_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  sdram_arbiter_if.master bus
);

  localparam int PTR_W = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_ACK   = 2'd1,
    WAIT_VALID = 2'd2
  } state_t;

  state_t                state_q,      state_d;
  logic                  owner_wr_q,   owner_wr_d;
  logic [PTR_W-1:0]      owner_q,      owner_d;
  logic [ADDR_WIDTH-1:0] sdram_addr_q, sdram_addr_d;
  logic [DATA_WIDTH-1:0] sdram_data_q, sdram_data_d;
  logic                  sdram_we_q,   sdram_we_d;
  logic                  sdram_req_q,  sdram_req_d;
  logic [NUM_PORTS-1:0]  port_valid_q, port_valid_d;
  logic [DATA_WIDTH-1:0] port_q_q,     port_q_d;

  logic                  wr_ack;
  logic [NUM_PORTS-1:0]  port_ack;
  logic                  win_found;
  logic [PTR_W-1:0]      win_idx;
  logic [ADDR_WIDTH-1:0] win_addr;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
`endif

  // Read winner selection.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_addr  = '0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    // Ports at or after the pointer are searched first; if none request,
    // the plain lowest-index scan below supplies the wrap-around winner.
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!win_found && bus.port_req[i] && (PTR_W'(i) >= rr_ptr_q)) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(i);
        win_addr  = bus.port_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
`endif
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!win_found && bus.port_req[i]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(i);
        win_addr  = bus.port_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    owner_wr_d   = owner_wr_q;
    owner_d      = owner_q;
    sdram_addr_d = sdram_addr_q;
    sdram_data_d = sdram_data_q;
    sdram_we_d   = sdram_we_q;
    sdram_req_d  = sdram_req_q;
    port_valid_d = '0;
    port_q_d     = port_q_q;
    wr_ack       = 1'b0;
    port_ack     = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.wr_req) begin
          sdram_addr_d = bus.wr_addr;
          sdram_data_d = bus.wr_data;
          sdram_we_d   = 1'b1;
          sdram_req_d  = 1'b1;
          owner_wr_d   = 1'b1;
          owner_d      = '0;
          state_d      = WAIT_ACK;
        end else if (win_found) begin
          sdram_addr_d = win_addr;
          sdram_we_d   = 1'b0;
          sdram_req_d  = 1'b1;
          owner_wr_d   = 1'b0;
          owner_d      = win_idx;
          state_d      = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        if (bus.sdram_ack) begin
          sdram_req_d = 1'b0;
          if (owner_wr_q) begin
            wr_ack  = 1'b1;
            state_d = IDLE;
          end else begin
            port_ack[owner_q] = 1'b1;
            state_d           = WAIT_VALID;
          end
        end
      end

      WAIT_VALID: begin
        if (bus.sdram_valid) begin
          port_q_d              = bus.sdram_q;
          port_valid_d[owner_q] = 1'b1;
          state_d               = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_wr_q   <= 1'b0;
      owner_q      <= '0;
      sdram_addr_q <= '0;
      sdram_data_q <= '0;
      sdram_we_q   <= 1'b0;
      sdram_req_q  <= 1'b0;
      port_valid_q <= '0;
      port_q_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_wr_q   <= owner_wr_d;
      owner_q      <= owner_d;
      sdram_addr_q <= sdram_addr_d;
      sdram_data_q <= sdram_data_d;
      sdram_we_q   <= sdram_we_d;
      sdram_req_q  <= sdram_req_d;
      port_valid_q <= port_valid_d;
      port_q_q     <= port_q_d;
    end
  end

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  // The pointer moves just past the port whose read was accepted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == WAIT_ACK && bus.sdram_ack && !owner_wr_q) begin
      if (owner_q == PTR_W'(NUM_PORTS - 1)) rr_ptr_d = '0;
      else                                  rr_ptr_d = owner_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rr_ptr_q <= '0;
    else          rr_ptr_q <= rr_ptr_d;
  end
`endif

  assign bus.wr_ack     = wr_ack;
  assign bus.port_ack   = port_ack;
  assign bus.port_valid = port_valid_q;
  assign bus.port_q     = port_q_q;
  assign bus.sdram_addr = sdram_addr_q;
  assign bus.sdram_data = sdram_data_q;
  assign bus.sdram_we   = sdram_we_q;
  assign bus.sdram_req  = sdram_req_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
//   Self-checking bench for sdram_arbiter (NUM_PORTS=4, 23-bit address,
//   32-bit data). Directed table of per-cycle vectors, hand-written priority
//   and reset sequences, then randomized traffic against a transaction-level
//   reference model.
module tb_sdram_arbiter;
  localparam int NP = 4;
  localparam int AW = 23;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sdram_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sdram_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          wr;
    logic [NP-1:0] preq;
    logic          ack;
    logic          val;
    logic [DW-1:0] q;
    logic          e_req;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic          e_wack;
    logic [NP-1:0] e_pack;
    logic [NP-1:0] e_pval;
    logic          e_busy;
    logic [DW-1:0] e_q;
  } vec_t;

  vec_t tbl[$];

  task automatic clear_inputs();
    bus.wr_req      = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.port_req    = '0;
    bus.port_addr   = '0;
    bus.sdram_ack   = 1'b0;
    bus.sdram_valid = 1'b0;
    bus.sdram_q     = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sdram_req"},  bus.sdram_req,  0);
    chk({tag, "_sdram_we"},   bus.sdram_we,   0);
    chk({tag, "_sdram_addr"}, bus.sdram_addr, 0);
    chk({tag, "_sdram_data"}, bus.sdram_data, 0);
    chk({tag, "_port_ack"},   bus.port_ack,   0);
    chk({tag, "_port_valid"}, bus.port_valid, 0);
    chk({tag, "_port_q"},     bus.port_q,     0);
    chk({tag, "_wr_ack"},     bus.wr_ack,     0);
    chk({tag, "_busy"},       bus.busy,       0);
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Acts as controller for one read: acks on the first cycle sdram_req is
  // seen, returns data the following cycle. Reports which port got the ack.
  task automatic serve_one(input bit drop, output int idx);
    int n;
    idx = -1;
    n = 0;
    @(negedge clk);
    while (bus.sdram_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk("grant_timeout", 1, 0);
      return;
    end
    @(posedge clk); #1 bus.sdram_ack = 1'b1;
    #1;
    chk("ack_onehot", $countones(bus.port_ack), 1);
    for (int i = 0; i < NP; i++) if (bus.port_ack[i]) idx = i;
    @(posedge clk); #1;
    bus.sdram_ack = 1'b0;
    if (drop && idx >= 0) bus.port_req[idx] = 1'b0;
    bus.sdram_valid = 1'b1;
    bus.sdram_q     = $urandom;
    @(posedge clk); #1 bus.sdram_valid = 1'b0;
  endtask

  // Reference model state: one outstanding transaction at most.
  logic          m_busy, m_acked, m_wr, m_we;
  int            m_port;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_q;
  logic [NP-1:0] m_valid;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  int            m_rr;
`endif

  function automatic int pick(input logic [NP-1:0] req);
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < NP; k++) if (req[(m_rr + k) % NP]) return (m_rr + k) % NP;
`else
    for (int k = 0; k < NP; k++) if (req[k]) return k;
`endif
    return -1;
  endfunction

  initial begin
    int idx, n, w;
    logic          seen_wack;
    logic [NP-1:0] seen_pack, e_pack;
    logic          e_wack;

    // wr, preq, ack, val, q | req, we, addr, wack, pack, pval, busy, port_q
    tbl.push_back('{0, 4'b0100, 0, 0, 32'h0,        0, 0, 23'h0,      0, 4'b0000, 4'b0000, 0, 32'h0});
    tbl.push_back('{0, 4'b0100, 0, 0, 32'h0,        1, 0, 23'h001234, 0, 4'b0000, 4'b0000, 1, 32'h0});
    tbl.push_back('{0, 4'b0100, 0, 0, 32'h0,        1, 0, 23'h001234, 0, 4'b0000, 4'b0000, 1, 32'h0});
    tbl.push_back('{0, 4'b0100, 0, 0, 32'h0,        1, 0, 23'h001234, 0, 4'b0000, 4'b0000, 1, 32'h0});
    tbl.push_back('{0, 4'b0100, 1, 0, 32'h0,        1, 0, 23'h001234, 0, 4'b0100, 4'b0000, 1, 32'h0});
    tbl.push_back('{0, 4'b0000, 0, 0, 32'h0,        0, 0, 23'h001234, 0, 4'b0000, 4'b0000, 1, 32'h0});
    tbl.push_back('{0, 4'b0000, 0, 1, 32'hDEADBEEF, 0, 0, 23'h001234, 0, 4'b0000, 4'b0000, 1, 32'h0});
    tbl.push_back('{0, 4'b0000, 0, 0, 32'h0,        0, 0, 23'h001234, 0, 4'b0000, 4'b0100, 0, 32'hDEADBEEF});
    tbl.push_back('{0, 4'b0000, 0, 0, 32'h0,        0, 0, 23'h001234, 0, 4'b0000, 4'b0000, 0, 32'hDEADBEEF});
    tbl.push_back('{1, 4'b0001, 0, 0, 32'h0,        0, 0, 23'h001234, 0, 4'b0000, 4'b0000, 0, 32'hDEADBEEF});
    tbl.push_back('{1, 4'b0001, 0, 0, 32'h0,        1, 1, 23'h000010, 0, 4'b0000, 4'b0000, 1, 32'hDEADBEEF});
    tbl.push_back('{1, 4'b0001, 1, 0, 32'h0,        1, 1, 23'h000010, 1, 4'b0000, 4'b0000, 1, 32'hDEADBEEF});
    tbl.push_back('{0, 4'b0001, 0, 1, 32'h55555555, 0, 1, 23'h000010, 0, 4'b0000, 4'b0000, 0, 32'hDEADBEEF});
    tbl.push_back('{0, 4'b0001, 0, 0, 32'h0,        1, 0, 23'h000ABC, 0, 4'b0000, 4'b0000, 1, 32'hDEADBEEF});
    tbl.push_back('{0, 4'b0001, 1, 0, 32'h0,        1, 0, 23'h000ABC, 0, 4'b0001, 4'b0000, 1, 32'hDEADBEEF});
    tbl.push_back('{0, 4'b0000, 0, 1, 32'hCAFEF00D, 0, 0, 23'h000ABC, 0, 4'b0000, 4'b0000, 1, 32'hDEADBEEF});
    tbl.push_back('{0, 4'b0000, 0, 0, 32'h0,        0, 0, 23'h000ABC, 0, 4'b0000, 4'b0001, 0, 32'hCAFEF00D});
    tbl.push_back('{0, 4'b0000, 0, 1, 32'h12345678, 0, 0, 23'h000ABC, 0, 4'b0000, 4'b0000, 0, 32'hCAFEF00D});
    tbl.push_back('{0, 4'b0000, 1, 0, 32'h0,        0, 0, 23'h000ABC, 0, 4'b0000, 4'b0000, 0, 32'hCAFEF00D});
    tbl.push_back('{0, 4'b0000, 0, 0, 32'h0,        0, 0, 23'h000ABC, 0, 4'b0000, 4'b0000, 0, 32'hCAFEF00D});

    // ---------------- directed table ----------------
    do_reset();
    bus.port_addr[2*AW +: AW] = 23'h001234;
    bus.port_addr[0*AW +: AW] = 23'h000ABC;
    bus.wr_addr = 23'h000010;
    bus.wr_data = 32'h11223344;
    foreach (tbl[r]) begin
      @(posedge clk); #1;
      bus.wr_req      = tbl[r].wr;
      bus.port_req    = tbl[r].preq;
      bus.sdram_ack   = tbl[r].ack;
      bus.sdram_valid = tbl[r].val;
      bus.sdram_q     = tbl[r].q;
      @(negedge clk);
      chk($sformatf("tbl%0d_sdram_req", r),  bus.sdram_req,  tbl[r].e_req);
      chk($sformatf("tbl%0d_sdram_we", r),   bus.sdram_we,   tbl[r].e_we);
      chk($sformatf("tbl%0d_sdram_addr", r), bus.sdram_addr, tbl[r].e_addr);
      chk($sformatf("tbl%0d_wr_ack", r),     bus.wr_ack,     tbl[r].e_wack);
      chk($sformatf("tbl%0d_port_ack", r),   bus.port_ack,   tbl[r].e_pack);
      chk($sformatf("tbl%0d_port_valid", r), bus.port_valid, tbl[r].e_pval);
      chk($sformatf("tbl%0d_busy", r),       bus.busy,       tbl[r].e_busy);
      chk($sformatf("tbl%0d_port_q", r),     bus.port_q,     tbl[r].e_q);
    end
    chk("write_data", bus.sdram_data, 32'h11223344);

    // ---------------- arbitration order ----------------
    do_reset();
    @(posedge clk); #1;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    bus.port_req = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      serve_one(1'b0, idx);
      chk($sformatf("rr_grant%0d", t), idx, t % NP);
    end
`else
    bus.port_req = 4'b1010;
    serve_one(1'b1, idx);
    chk("fixed_first", idx, 1);
    serve_one(1'b1, idx);
    chk("fixed_second", idx, 3);
`endif
    bus.port_req = '0;

    // ---------------- reset during WAIT_VALID ----------------
    do_reset();
    @(posedge clk); #1;
    bus.port_addr[0 +: AW] = 23'h000321;
    bus.port_req = 4'b0001;
    n = 0;
    @(negedge clk);
    while (bus.sdram_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("midrst_req_seen", bus.sdram_req, 1);
    @(posedge clk); #1 bus.sdram_ack = 1'b1;
    @(posedge clk); #1 bus.sdram_ack = 1'b0; bus.port_req = '0;
    @(negedge clk);
    chk("midrst_busy_before", bus.busy, 1);
    reset_n = 1'b0;
    #1 chk_all_zero("midrst");
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1 bus.sdram_valid = 1'b1; bus.sdram_q = 32'hBADC0DE5;
    @(posedge clk); #1 bus.sdram_valid = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk_all_zero("post_midrst");
    end

    // ---------------- randomized traffic vs model ----------------
    do_reset();
    m_busy = 0; m_acked = 0; m_wr = 0; m_we = 0; m_port = 0;
    m_addr = '0; m_data = '0; m_q = '0; m_valid = '0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    m_rr = 0;
`endif
    seen_wack = 0; seen_pack = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk); #1;
      if (seen_wack) bus.wr_req = 1'b0;
      for (int i = 0; i < NP; i++) if (seen_pack[i]) bus.port_req[i] = 1'b0;
      if (!bus.wr_req && $urandom_range(15) == 0) begin
        bus.wr_req  = 1'b1;
        bus.wr_addr = AW'($urandom);
        bus.wr_data = $urandom;
      end
      for (int i = 0; i < NP; i++) begin
        if (!bus.port_req[i] && $urandom_range(3) == 0) begin
          bus.port_req[i] = 1'b1;
          bus.port_addr[i*AW +: AW] = AW'($urandom);
        end
      end
      bus.sdram_ack   = ($urandom_range(2) == 0);
      bus.sdram_valid = ($urandom_range(2) == 0);
      bus.sdram_q     = $urandom;
      @(negedge clk);

      e_wack = m_busy && !m_acked && m_wr && bus.sdram_ack;
      e_pack = '0;
      if (m_busy && !m_acked && !m_wr && bus.sdram_ack) e_pack[m_port] = 1'b1;
      chk("rnd_sdram_req",  bus.sdram_req,  m_busy && !m_acked);
      chk("rnd_sdram_we",   bus.sdram_we,   m_we);
      chk("rnd_sdram_addr", bus.sdram_addr, m_addr);
      chk("rnd_sdram_data", bus.sdram_data, m_data);
      chk("rnd_busy",       bus.busy,       m_busy);
      chk("rnd_wr_ack",     bus.wr_ack,     e_wack);
      chk("rnd_port_ack",   bus.port_ack,   e_pack);
      chk("rnd_port_valid", bus.port_valid, m_valid);
      chk("rnd_port_q",     bus.port_q,     m_q);
      seen_wack = bus.wr_ack;
      seen_pack = bus.port_ack;

      // Advance the model by one clock using this cycle's inputs.
      m_valid = '0;
      if (!m_busy) begin
        if (bus.wr_req) begin
          m_busy = 1; m_acked = 0; m_wr = 1; m_we = 1;
          m_addr = bus.wr_addr; m_data = bus.wr_data;
        end else if (bus.port_req != '0) begin
          w = pick(bus.port_req);
          m_busy = 1; m_acked = 0; m_wr = 0; m_we = 0; m_port = w;
          m_addr = bus.port_addr[w*AW +: AW];
        end
      end else if (!m_acked) begin
        if (bus.sdram_ack) begin
          m_acked = 1;
          if (m_wr) m_busy = 0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
          else m_rr = (m_port + 1) % NP;
`endif
        end
      end else if (bus.sdram_valid) begin
        m_valid[m_port] = 1'b1;
        m_q    = bus.sdram_q;
        m_busy = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
